core_hazard_ctrl: RTL and testbench

- Scoreboard and forwarding controller for the 4-stage integer pipeline (ID -> EX -> MEM -> WB).
- Tracks the destination register of every in-flight instruction in shadow slots and detects load-use hazards.
- Generates the decode-stage stall, the EX issue strobe and the operand forwarding selects that steer the ALU operand muxes.
- Sits beside core_decoder and consumes its rs1/rs2/rd addresses plus per-instruction use/write/load flags.

---
 rtl/core_hazard_ctrl.sv | 130 +++++++++++++
 tb/tb_core_hazard_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_hazard_ctrl.sv
// Scoreboard and forwarding controller for the ID/EX/MEM/WB integer pipeline.
// Tracks in-flight destinations, detects load-use hazards and steers ALU operand muxes.
module core_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
  input  logic [REG_ADDR_W-1:0] id_rd_addr_i,
  input  logic                  id_use_rs1_i,
  input  logic                  id_use_rs2_i,
  input  logic                  id_rd_we_i,
  input  logic                  id_is_load_i,
  input  logic                  flush_i,
  input  logic                  mem_stall_i,
  output logic                  stall_o,
  output logic                  issue_o,
  output logic [1:0]            fwd_rs1_sel_o,
  output logic [1:0]            fwd_rs2_sel_o,
  output logic [CNT_W-1:0]      stall_cnt_o
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EX  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;
  localparam logic [1:0] SEL_WB  = 2'b11;

  logic                  ex_vld,  mem_vld,  wb_vld;
  logic [REG_ADDR_W-1:0] ex_rd,   mem_rd,   wb_rd;
  logic                  ex_we,   mem_we,   wb_we;
  logic                  ex_ld,   mem_ld,   wb_ld;
  logic [CNT_W-1:0]      stall_cnt;

  logic m_ex1, m_mem1, m_wb1;
  logic m_ex2, m_mem2, m_wb2;
  logic load_use;
  logic stall;
  logic issue;

  function automatic logic slot_match(
    input logic                  vld,
    input logic                  we,
    input logic [REG_ADDR_W-1:0] rd,
    input logic [REG_ADDR_W-1:0] rs
  );
    return vld && we && (rd == rs) && (rs != '0);
  endfunction

  // Youngest producer wins: EX before MEM before WB.
  function automatic logic [1:0] fwd_sel(
    input logic used,
    input logic hit_ex,
    input logic hit_mem,
    input logic hit_wb
  );
    logic [1:0] sel;
    sel = SEL_RF;
    if (used) begin
      if (hit_ex)       sel = SEL_EX;
      else if (hit_mem) sel = SEL_MEM;
      else if (hit_wb)  sel = SEL_WB;
    end
    return sel;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    return (&val) ? val : val + CNT_W'(1);
  endfunction

  always_comb begin
    m_ex1  = slot_match(ex_vld,  ex_we,  ex_rd,  id_rs1_addr_i);
    m_mem1 = slot_match(mem_vld, mem_we, mem_rd, id_rs1_addr_i);
    m_wb1  = slot_match(wb_vld,  wb_we,  wb_rd,  id_rs1_addr_i);
    m_ex2  = slot_match(ex_vld,  ex_we,  ex_rd,  id_rs2_addr_i);
    m_mem2 = slot_match(mem_vld, mem_we, mem_rd, id_rs2_addr_i);
    m_wb2  = slot_match(wb_vld,  wb_we,  wb_rd,  id_rs2_addr_i);
  end

  // A load still in EX has no data yet; one in MEM can forward its load result.
  assign load_use = id_valid_i && ex_ld &&
                    ((id_use_rs1_i && m_ex1) || (id_use_rs2_i && m_ex2));
  assign stall    = load_use || mem_stall_i;
  assign issue    = id_valid_i && !stall && !flush_i;

  assign stall_o       = stall;
  assign issue_o       = issue;
  assign fwd_rs1_sel_o = fwd_sel(id_valid_i && id_use_rs1_i, m_ex1, m_mem1, m_wb1);
  assign fwd_rs2_sel_o = fwd_sel(id_valid_i && id_use_rs2_i, m_ex2, m_mem2, m_wb2);
  assign stall_cnt_o   = stall_cnt;

  // Slot occupancy and the stall counter are the only reset state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_vld    <= 1'b0;
      mem_vld   <= 1'b0;
      wb_vld    <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (mem_stall_i) begin
        if (flush_i) ex_vld <= 1'b0;
      end else begin
        wb_vld  <= mem_vld;
        mem_vld <= ex_vld;
        ex_vld  <= issue;
      end
      if (load_use) stall_cnt <= sat_inc(stall_cnt);
    end
  end

  // Slot payload is qualified by the valid bits, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (!mem_stall_i) begin
      wb_rd  <= mem_rd;
      wb_we  <= mem_we;
      wb_ld  <= mem_ld;
      mem_rd <= ex_rd;
      mem_we <= ex_we;
      mem_ld <= ex_ld;
      if (issue) begin
        ex_rd <= id_rd_addr_i;
        ex_we <= id_rd_we_i;
        ex_ld <= id_is_load_i;
      end
    end
  end

endmodule

// File: tb/tb_core_hazard_ctrl.sv
// Scenario bench for core_hazard_ctrl: each row drives one ID cycle and queues
// the outputs expected for that cycle {stall, issue, fwd1, fwd2, stall_cnt}.
module tb_core_hazard_ctrl;

  localparam int AW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid;
  logic [AW-1:0] rs1, rs2, rd;
  logic          use1, use2, we, is_load, flush, mem_stall;
  logic          stall, issue;
  logic [1:0]    f1, f2;
  logic [CW-1:0] cnt;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic          v;
    logic [AW-1:0] rs1;
    logic          u1;
    logic [AW-1:0] rs2;
    logic          u2;
    logic [AW-1:0] rd;
    logic          we;
    logic          ld;
    logic          fl;
    logic          ms;
    logic [9:0]    exp;
  } row_t;

  logic [9:0] exp_q[$];

  core_hazard_ctrl #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid),
    .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2), .id_rd_addr_i(rd),
    .id_use_rs1_i(use1), .id_use_rs2_i(use2), .id_rd_we_i(we),
    .id_is_load_i(is_load), .flush_i(flush), .mem_stall_i(mem_stall),
    .stall_o(stall), .issue_o(issue), .fwd_rs1_sel_o(f1),
    .fwd_rs2_sel_o(f2), .stall_cnt_o(cnt)
  );

  always #5 clk = ~clk;

  function automatic row_t mk(
    input logic v, input logic [AW-1:0] r1, input logic u1,
    input logic [AW-1:0] r2, input logic u2, input logic [AW-1:0] d,
    input logic w, input logic l, input logic fl, input logic ms,
    input logic st, input logic is, input logic [1:0] s1, input logic [1:0] s2,
    input logic [CW-1:0] c);
    row_t r;
    r.v = v; r.rs1 = r1; r.u1 = u1; r.rs2 = r2; r.u2 = u2; r.rd = d;
    r.we = w; r.ld = l; r.fl = fl; r.ms = ms;
    r.exp = {st, is, s1, s2, c};
    return r;
  endfunction

  task automatic apply(input row_t r);
    id_valid = r.v; rs1 = r.rs1; use1 = r.u1; rs2 = r.rs2; use2 = r.u2;
    rd = r.rd; we = r.we; is_load = r.ld; flush = r.fl; mem_stall = r.ms;
    exp_q.push_back(r.exp);
  endtask

  task automatic idle_inputs();
    id_valid = 0; rs1 = 0; rs2 = 0; rd = 0; use1 = 0; use2 = 0;
    we = 0; is_load = 0; flush = 0; mem_stall = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    row_t rows[$];
    logic [9:0] got, want;
    rows.push_back(mk(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 1, 2'b00, 2'b00, 0));
    rows.push_back(mk(1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b01, 2'b00, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
    rows.push_back(mk(1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0));
    foreach (rows[i]) begin
      if (i == 2) do_reset();
      apply(rows[i]);
      @(negedge clk);
      got = {stall, issue, f1, f2, cnt};
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL reset row%0d {stall,issue,f1,f2,cnt} got=%b want=%b", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    row_t rows[$];
    logic [9:0] got, want;
    rows.push_back(mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0));
    rows.push_back(mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 0));
    rows.push_back(mk(1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 0));
    rows.push_back(mk(1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b11, 0));
    rows.push_back(mk(1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0));
    rows.push_back(mk(1, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0));
    rows.push_back(mk(0, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
    rows.push_back(mk(1, 6, 0, 6, 1, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 0));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      got = {stall, issue, f1, f2, cnt};
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL back_to_back row%0d {stall,issue,f1,f2,cnt} got=%b want=%b", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    row_t rows[$];
    logic [9:0] got, want;
    rows.push_back(mk(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 1, 2'b00, 2'b00, 0));
    rows.push_back(mk(1, 7, 1, 0, 0, 8, 1, 0, 0, 0, 1, 0, 2'b01, 2'b00, 0));
    rows.push_back(mk(1, 7, 1, 0, 0, 8, 1, 0, 0, 0, 0, 1, 2'b10, 2'b00, 1));
    rows.push_back(mk(1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 1));
    rows.push_back(mk(1, 0, 0, 0, 0, 10, 1, 1, 0, 0, 0, 1, 2'b00, 2'b00, 1));
    rows.push_back(mk(1, 0, 0, 10, 1, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b01, 1));
    rows.push_back(mk(1, 0, 0, 10, 1, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      got = {stall, issue, f1, f2, cnt};
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL load_use row%0d {stall,issue,f1,f2,cnt} got=%b want=%b", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_x0_priority();
    row_t rows[$];
    logic [9:0] got, want;
    rows.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 2'b00, 2'b00, 2));
    rows.push_back(mk(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2));
    rows.push_back(mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2));
    rows.push_back(mk(1, 3, 1, 0, 0, 3, 1, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2));
    rows.push_back(mk(1, 3, 1, 3, 1, 3, 0, 0, 0, 0, 0, 1, 2'b01, 2'b01, 2));
    rows.push_back(mk(1, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      got = {stall, issue, f1, f2, cnt};
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL x0_priority row%0d {stall,issue,f1,f2,cnt} got=%b want=%b", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flush();
    row_t rows[$];
    logic [9:0] got, want;
    rows.push_back(mk(1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 0, 1, 2'b00, 2'b00, 2));
    rows.push_back(mk(1, 0, 0, 4, 1, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b01, 2));
    rows.push_back(mk(1, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 3));
    rows.push_back(mk(1, 0, 0, 0, 0, 11, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 3));
    rows.push_back(mk(1, 11, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      got = {stall, issue, f1, f2, cnt};
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL flush row%0d {stall,issue,f1,f2,cnt} got=%b want=%b", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mem_stall();
    row_t rows[$];
    logic [9:0] got, want;
    rows.push_back(mk(1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0, 1, 2'b00, 2'b00, 3));
    rows.push_back(mk(1, 0, 0, 0, 0, 12, 1, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3));
    rows.push_back(mk(1, 9, 1, 12, 1, 0, 0, 0, 0, 1, 1, 0, 2'b10, 2'b01, 3));
    rows.push_back(mk(1, 9, 1, 12, 1, 0, 0, 0, 0, 1, 1, 0, 2'b10, 2'b01, 3));
    rows.push_back(mk(1, 9, 1, 12, 1, 0, 0, 0, 1, 1, 1, 0, 2'b10, 2'b01, 3));
    rows.push_back(mk(1, 9, 1, 12, 1, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      got = {stall, issue, f1, f2, cnt};
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL mem_stall row%0d {stall,issue,f1,f2,cnt} got=%b want=%b", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_saturation();
    row_t rows[$];
    logic [9:0] got, want;
    logic [CW-1:0] c;
    for (int k = 0; k <= 16; k++) begin
      c = (k > 15) ? CW'(15) : CW'(k);
      rows.push_back(mk(1, 0, 0, 0, 0, 13, 1, 1, 0, 0, 0, 1, 2'b00, 2'b00, c));
      rows.push_back(mk(1, 13, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b01, 2'b00, c));
    end
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 15));
    do_reset();
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      got = {stall, issue, f1, f2, cnt};
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL saturation row%0d {stall,issue,f1,f2,cnt} got=%b want=%b", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();
    test_reset();
    test_back_to_back();
    test_load_use();
    test_x0_priority();
    test_flush();
    test_mem_stall();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
